// File: rtl/cbit_sweeper.sv
// Background read-and-clear scanner for the access-bit BRAM port 1.
// Entries whose cbit was still 0 are streamed out, in ascending order, as cold candidates.
module cbit_sweeper #(
    parameter int L2_DEPTH       = 8,
    parameter int SWEEP_INTERVAL = 1024,
    parameter int L2_FIFO        = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    output logic [L2_DEPTH-1:0] addr1,
    output logic                en1,
    output logic                we1,
    output logic                din1,
    output logic                rst1,
    output logic                regce1,
    input  logic                dout1,
    output logic                evict_valid,
    output logic [L2_DEPTH-1:0] evict_addr,
    input  logic                evict_ready,
    output logic                sweep_done,
    output logic [L2_DEPTH-1:0] sweep_cold_cnt,
    output logic [1:0]          dbg_state
);

    localparam int DEPTH      = 1 << L2_DEPTH;
    localparam int FIFO_DEPTH = 1 << L2_FIFO;
    localparam int CW         = $clog2(SWEEP_INTERVAL + 1);
    localparam int OW         = L2_FIFO + 2;
    localparam logic [L2_DEPTH-1:0] PARK = L2_DEPTH'(DEPTH - 1);
    localparam logic [L2_DEPTH-1:0] LAST = L2_DEPTH'(DEPTH - 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [L2_DEPTH-1:0]   scan_ptr_q, scan_ptr_d;
    logic [L2_DEPTH-1:0]   addr1_q, addr1_d;
    logic                  en1_q, en1_d;
    logic                  s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [L2_DEPTH-1:0]   s1_a_q, s1_a_d, s2_a_q, s2_a_d;
    logic [L2_DEPTH-1:0]   cold_q, cold_d;
    logic [L2_DEPTH-1:0]   cold_out_q, cold_out_d;
    logic                  done_q, done_d;
    logic [L2_DEPTH-1:0]   mem_q [FIFO_DEPTH];
    logic [L2_DEPTH-1:0]   mem_d [FIFO_DEPTH];
    logic [L2_FIFO-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [L2_FIFO:0]      count_q, count_d;

    logic                  push, pop, can_issue, last_capture;
    logic [OW-1:0]         occ;

    // Stream handshake: a candidate transfers on every clock edge where evict_valid and
    // evict_ready are both 1; while valid is high and ready low, evict_addr holds its value.
    assign push         = s2_v_q && !dout1;
    assign evict_valid  = (count_q != '0);
    assign pop          = evict_valid && evict_ready;
    // Every issued address that has not yet landed still owns a FIFO slot.
    assign occ          = OW'(count_q) + OW'(en1_q) + OW'(s1_v_q) + OW'(s2_v_q);
    assign can_issue    = occ < OW'(FIFO_DEPTH);
    assign last_capture = s2_v_q && !s1_v_q && !en1_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        scan_ptr_d = scan_ptr_q;
        addr1_d    = PARK;
        en1_d      = 1'b0;
        s1_v_d     = en1_q;
        s1_a_d     = addr1_q;
        s2_v_d     = s1_v_q;
        s2_a_d     = s1_a_q;
        cold_d     = push ? cold_q + L2_DEPTH'(1) : cold_q;
        cold_out_d = cold_out_q;
        done_d     = 1'b0;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q + L2_FIFO'(push);
        rd_ptr_d   = rd_ptr_q + L2_FIFO'(pop);
        count_d    = count_q + (L2_FIFO+1)'(push) - (L2_FIFO+1)'(pop);
        if (push) mem_d[wr_ptr_q] = s2_a_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == CW'(SWEEP_INTERVAL - 1)) begin
                    state_d    = S_SCAN;
                    scan_ptr_d = '0;
                    cold_d     = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            S_SCAN: begin
                if (can_issue) begin
                    addr1_d    = scan_ptr_q;
                    en1_d      = 1'b1;
                    scan_ptr_d = scan_ptr_q + L2_DEPTH'(1);
                    if (scan_ptr_q == LAST) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_capture) begin
                    done_d     = 1'b1;
                    cold_out_d = cold_d;
                    wait_cnt_d = '0;
                    state_d    = enable ? S_WAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            scan_ptr_q <= '0;
            addr1_q    <= PARK;
            en1_q      <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s2_v_q     <= 1'b0;
            s2_a_q     <= '0;
            cold_q     <= '0;
            cold_out_q <= '0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            scan_ptr_q <= scan_ptr_d;
            addr1_q    <= addr1_d;
            en1_q      <= en1_d;
            s1_v_q     <= s1_v_d;
            s1_a_q     <= s1_a_d;
            s2_v_q     <= s2_v_d;
            s2_a_q     <= s2_a_d;
            cold_q     <= cold_d;
            cold_out_q <= cold_out_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    // The issue throttle must make this unreachable.
    always_ff @(posedge clk) begin
        if (resetn) assert (!(push && count_q == (L2_FIFO+1)'(FIFO_DEPTH)));
    end

    assign addr1          = addr1_q;
    assign en1            = en1_q;
    assign we1            = 1'b0;
    assign din1           = 1'b0;
    assign rst1           = 1'b0;
    assign regce1         = 1'b1;
    assign evict_addr     = mem_q[rd_ptr_q];
    assign sweep_done     = done_q;
    assign sweep_cold_cnt = cold_out_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_cbit_sweeper.sv
// Directed bench for cbit_sweeper with a behavioural read-and-clear BRAM on port 1
// and an expected-candidate queue fed from the bench's own record of port-2 reads.
module tb_cbit_sweeper;

    localparam int DEPTH = 16;
    localparam logic [3:0] PARK    = 4'd15;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd2;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] addr1;
    logic       en1, we1, din1, rst1, regce1;
    logic       dout1;
    logic       evict_valid;
    logic [3:0] evict_addr;
    logic       evict_ready = 1'b0;
    logic       sweep_done;
    logic [3:0] sweep_cold_cnt;
    logic [1:0] dbg_state;

    cbit_sweeper #(.L2_DEPTH(4), .SWEEP_INTERVAL(16), .L2_FIFO(2)) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .addr1(addr1), .en1(en1), .we1(we1), .din1(din1), .rst1(rst1), .regce1(regce1),
        .dout1(dout1),
        .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_ready(evict_ready),
        .sweep_done(sweep_done), .sweep_cold_cnt(sweep_cold_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Access-bit BRAM: port 1 reads and clears the registered address every cycle,
    // output register gives two cycles of latency; port 2 sets a bit on a read.
    logic       cbit [DEPTH];
    logic       ram_q;
    logic       bram_clr = 1'b1;
    logic       p2_we = 1'b0;
    logic [3:0] p2_addr = 4'd0;

    always @(posedge clk) begin
        if (bram_clr) begin
            for (int i = 0; i < DEPTH; i++) cbit[i] <= 1'b0;
            ram_q <= 1'b0;
            dout1 <= 1'b0;
        end else begin
            ram_q       <= cbit[addr1];
            dout1       <= ram_q;
            cbit[addr1] <= 1'b0;
            if (p2_we) cbit[p2_addr] <= 1'b1;
        end
    end

    int         n_cmp = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         sweep_total = 0;
    int         issue_cnt = 0;
    logic [3:0] last_issued = 4'd0;
    logic       rand_ready = 1'b0;
    logic       touched [DEPTH];
    logic [3:0] exp_q [$];
    logic       prev_hold = 1'b0;
    logic [3:0] prev_addr = 4'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) evict_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic p2_read(input int a);
        p2_addr = 4'(a);
        p2_we = 1'b1;
        touched[a] = 1'b1;
        tick();
        p2_we = 1'b0;
    endtask

    task automatic expect_sweep(output int cnt);
        cnt = 0;
        for (int a = 0; a < DEPTH - 1; a++) begin
            if (!touched[a]) begin
                exp_q.push_back(4'(a));
                cnt++;
            end
            touched[a] = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        sweep_total++;
        chk(tag, done_cnt - start, 1);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || evict_valid) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_issue(input logic [3:0] a, input int budget, input string tag);
        int n = 0;
        while (!(en1 === 1'b1 && addr1 === a) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {en1, addr1}, {1'b1, a});
    endtask

    // Monitor: park address, candidate order, hold stability, done pulses.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_hold = 1'b0;
        end else begin
            if (en1) begin
                chk("issue_in_range", 32'(addr1 < PARK), 1);
                last_issued = addr1;
                issue_cnt++;
            end else begin
                chk("park_addr", addr1, PARK);
            end
            if (prev_hold) begin
                chk("hold_valid", evict_valid, 1);
                chk("hold_addr", evict_addr, prev_addr);
            end
            if (evict_valid && evict_ready) begin
                if (exp_q.size() == 0) chk("extra_candidate", evict_addr, 32'hdead);
                else chk("candidate", evict_addr, exp_q.pop_front());
            end
            prev_hold = evict_valid && !evict_ready;
            prev_addr = evict_addr;
            if (sweep_done) done_cnt++;
        end
    end

    initial begin
        int cnt;
        int snap;
        for (int i = 0; i < DEPTH; i++) touched[i] = 1'b0;

        // Reset values
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr1", addr1, PARK);
        chk("rst_en1", en1, 0);
        chk("rst_valid", evict_valid, 0);
        chk("rst_evict_addr", evict_addr, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_cold", sweep_cold_cnt, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("const_ports", {we1, din1, rst1, regce1}, 4'b0001);
        resetn = 1'b1;
        bram_clr = 1'b0;
        repeat (5) tick();
        chk("idle_no_enable", dbg_state, ST_IDLE);

        // 1: all bits clear -> 0..14
        evict_ready = 1'b1;
        enable = 1'b1;
        expect_sweep(cnt);
        wait_done(400, "t1_done");
        chk("t1_cold", sweep_cold_cnt, 15);
        chk("t1_done_pulse_width", sweep_done, 0);

        // 2: reads of 3 and 7 hide them for one sweep only
        p2_read(3);
        p2_read(7);
        expect_sweep(cnt);
        wait_done(400, "t2_done");
        chk("t2_cold", sweep_cold_cnt, 13);
        expect_sweep(cnt);
        wait_done(400, "t2b_done");
        chk("t2b_cold", sweep_cold_cnt, 15);
        drain(50, "t2_drain");

        // 3: consumer blocked for a whole sweep
        evict_ready = 1'b0;
        expect_sweep(cnt);
        begin
            int n = 0;
            while (dbg_state !== ST_SCAN && n < 60) begin tick(); n++; end
        end
        chk("t3_in_scan", dbg_state, ST_SCAN);
        repeat (30) tick();
        chk("t3_stall_state", dbg_state, ST_SCAN);
        chk("t3_valid", evict_valid, 1);
        chk("t3_head", evict_addr, 0);
        chk("t3_stall_addr1", addr1, PARK);
        chk("t3_stall_en1", en1, 0);
        chk("t3_last_issued", last_issued, 3);
        evict_ready = 1'b1;
        wait_done(400, "t3_done");
        chk("t3_cold", sweep_cold_cnt, 15);
        drain(50, "t3_drain");

        // 4: asynchronous reset mid-scan
        expect_sweep(cnt);
        wait_issue(4'd6, 80, "t4_reach_6");
        resetn = 1'b0;
        #1;
        chk("t4_valid", evict_valid, 0);
        chk("t4_addr1", addr1, PARK);
        chk("t4_en1", en1, 0);
        chk("t4_state", dbg_state, ST_IDLE);
        chk("t4_cold_out", sweep_cold_cnt, 0);
        exp_q.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        expect_sweep(cnt);
        wait_done(400, "t4_done");
        chk("t4_cold", sweep_cold_cnt, 15);
        drain(50, "t4_drain");

        // 5: enable dropped mid-scan lets the sweep finish, then stays idle
        expect_sweep(cnt);
        wait_issue(4'd4, 80, "t5_reach_4");
        enable = 1'b0;
        wait_done(400, "t5_done");
        chk("t5_cold", sweep_cold_cnt, 15);
        drain(50, "t5_drain");
        snap = issue_cnt;
        repeat (120) tick();
        chk("t5_no_issue", issue_cnt - snap, 0);
        chk("t5_idle", dbg_state, ST_IDLE);
        chk("t5_en1", en1, 0);

        // 6: random port-2 reads between sweeps, random consumer stalls
        enable = 1'b1;
        rand_ready = 1'b1;
        for (int s = 0; s < 50; s++) begin
            int nr = $urandom_range(0, 4);
            for (int r = 0; r < nr; r++) p2_read($urandom_range(0, 14));
            expect_sweep(cnt);
            wait_done(1000, "t6_done");
            chk("t6_cold", sweep_cold_cnt, cnt);
        end
        enable = 1'b0;
        rand_ready = 1'b0;
        evict_ready = 1'b1;
        drain(200, "t6_drain");
        chk("done_total", done_cnt, sweep_total);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
